mynios2_cpu_oci_mem_ctrl: RTL and testbench
===========================================

// Module: mynios2_cpu_oci_mem_ctrl
// PURPOSE
//  Sysclk-side consumer of the JTAG debug module's jdo bus and ocimem strobes. Owns the on-chip
//  debug RAM, shared by JTAG host reads/writes and the CPU's Avalon debug slave. Returns
//  MonDReg/monitor_ready/monitor_error to the JTAG tck stage for capture on the next scan.
// PARAMETERS
//  ADDR_W   8   word-address width; RAM depth = 2**ADDR_W 32-bit words
// PORTS
//  clk                      in   1   system clock
//  reset_n                  in   1   async active-low reset
//  jdo                      in   38  JTAG data, stable whenever a take_* strobe is high
//  take_action_ocimem_a     in   1   1-cycle: load address/control from jdo
//  take_no_action_ocimem_a  in   1   1-cycle: JTAG read at current address
//  take_action_ocimem_b     in   1   1-cycle: JTAG write jdo[34:3] at current address
//  debugack                 in   1   CPU is in debug mode
//  av_address               in   ADDR_W  CPU word address
//  av_read / av_write       in   1   CPU access request; held until av_waitrequest low
//  av_writedata             in   32  CPU write data
//  av_byteenable            in   4   CPU byte lanes
//  av_readdata              out  32  CPU read data, valid in the cycle av_waitrequest is low on a read
//  av_waitrequest           out  1   stall to CPU
//  MonDReg                  out  32  last JTAG read data
//  monitor_ready            out  1   last JTAG op complete
//  monitor_error            out  1   sticky: CPU write rejected
// BEHAVIOUR
//  Reset: MonDReg=0, monitor_ready=0, monitor_error=0, av_readdata=0, av_waitrequest=1,
//   address=0, FSM=IDLE, pending=0. Reset mid-operation abandons the op; RAM contents unaffected.
//  ocimem_a (1 cycle, no RAM access): address <= jdo[17+ADDR_W-1:17]; if jdo[35], monitor_error <= 0.
//   monitor_ready <= 0.
//  Strobe priority in one cycle: ocimem_a > ocimem_b > no_action_ocimem_a; lower strobes dropped.
//  FSM: IDLE, JRD, JCAP, JWR, CRD.
//   IDLE: accepted JTAG rd -> JRD; JTAG wr -> JWR; else CPU read -> CRD; CPU write completes in IDLE.
//   JRD: RAM sync read issued (1-cycle RAM latency) -> JCAP.
//   JCAP: MonDReg <= RAM q; monitor_ready <= 1; address++ -> IDLE. MonDReg updates 2 cycles after strobe.
//   JWR: RAM[address] <= jdo[34:3] (all lanes); monitor_ready <= 1; address++ -> IDLE.
//   CRD: av_readdata <= RAM q; av_waitrequest low this cycle -> IDLE.
//  monitor_ready <= 0 the cycle a JTAG rd/wr is accepted.
//  address is ADDR_W bits; increments wrap modulo 2**ADDR_W (all-ones -> 0).
//  Arbitration: JTAG has priority. av_waitrequest=1 unless FSM in IDLE with no JTAG strobe/pending
//   (CPU write completes) or FSM in CRD. CPU read latency 2 cycles when uncontended.
//  JTAG strobe arriving while FSM is not IDLE sets a one-deep pending slot (op + jdo[34:3] latched);
//   served at next IDLE ahead of CPU. Second strobe while pending set is dropped.
//  CPU write with debugack=0: completes (waitrequest low), RAM unchanged, monitor_error <= 1.
//  CPU write with debugack=1: byte lanes per av_byteenable.
//  av_read and av_write together: treated as read.
// CONFIGURATION
//  MYNIOS2_OCIMEM_AUTOINC_EN defined: address increments after each JTAG rd/wr as above.
//  Not defined: address changes only via ocimem_a; JCAP/JWR leave address unchanged.
// TESTING
//  Reset: MonDReg=0, monitor_ready=0, av_waitrequest=1 until first cycle after reset release.
//  ocimem_a jdo[24:17]=0x10, ocimem_b jdo[34:3]=0xDEADBEEF, ocimem_a addr 0x10, no_action rd
//   -> MonDReg=0xDEADBEEF 2 cycles later, monitor_ready=1.
//  Autoinc on: addr 0xFF, two writes 0x1,0x2 -> RAM[0xFF]=0x1, RAM[0x00]=0x2; macro off -> RAM[0xFF]=0x2.
//  CPU read 0x10 asserted same cycle as JTAG wr to 0x10 -> JTAG first; av_readdata=new value,
//   waitrequest low 4 cycles after request.
//  debugack=0, CPU write 0x20=0x1234 -> RAM[0x20] unchanged, monitor_error=1; ocimem_a jdo[35]=1 clears.
//  debugack=1, byteenable=4'b0010, write 0xAABBCCDD over 0 -> RAM word reads back 0x0000CC00.

Source files
------------

// File: rtl/mynios2_cpu_oci_mem_ctrl.sv
// mynios2_cpu_oci_mem_ctrl: system-clock side of the OCI debug memory.
// Owns the debug RAM, which is shared by JTAG host accesses (arriving as
// ocimem strobes with a jdo payload) and the CPU Avalon debug slave. JTAG
// has priority; a JTAG op that arrives while the engine is busy is parked
// in a one-deep pending slot.
// Build option: define MYNIOS2_OCIMEM_AUTOINC_EN to post-increment the
// JTAG address after every JTAG read/write. Without it, the address only
// changes through ocimem_a.
module mynios2_cpu_oci_mem_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              debugack,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned DATA_W = 32;

`ifdef MYNIOS2_OCIMEM_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    JRD  = 3'd1,
    JCAP = 3'd2,
    JWR  = 3'd3,
    CRD  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                pend_q, pend_d;
  logic                pend_wr_q, pend_wr_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   mondreg_d;
  logic                ready_d;
  logic                error_d;
  logic [DATA_W-1:0]   rdata_d;
  logic                wait_d;

  // RAM port controls
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [3:0]          ram_be;
  logic [ADDR_W-1:0]   ram_raddr;
  logic [DATA_W-1:0]   ram_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Decoded strobes: ocimem_a masks both ops, a write masks a read
  logic                strobe_a;
  logic                strobe_wr;
  logic                strobe_rd;
  logic                jtag_op;
  logic                cpu_req;
  logic                unused_jdo;

  assign strobe_a   = take_action_ocimem_a;
  assign strobe_wr  = !take_action_ocimem_a && take_action_ocimem_b;
  assign strobe_rd  = !take_action_ocimem_a && !take_action_ocimem_b &&
                      take_no_action_ocimem_a;
  assign jtag_op    = strobe_wr || strobe_rd;
  // A low waitrequest means the current CPU access is completing this cycle
  assign cpu_req    = av_waitrequest && (av_read || av_write);
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // Debug RAM: synchronous read, byte-lane write
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) mem[ram_waddr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    ram_q <= mem[ram_raddr];
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      pend_q         <= 1'b0;
      pend_wr_q      <= 1'b0;
      pend_data_q    <= '0;
      wdata_q        <= '0;
      MonDReg        <= '0;
      monitor_ready  <= 1'b0;
      monitor_error  <= 1'b0;
      av_readdata    <= '0;
      av_waitrequest <= 1'b1;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      pend_q         <= pend_d;
      pend_wr_q      <= pend_wr_d;
      pend_data_q    <= pend_data_d;
      wdata_q        <= wdata_d;
      MonDReg        <= mondreg_d;
      monitor_ready  <= ready_d;
      monitor_error  <= error_d;
      av_readdata    <= rdata_d;
      av_waitrequest <= wait_d;
    end
  end

  // Next-state, arbitration and RAM control
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pend_d      = pend_q;
    pend_wr_d   = pend_wr_q;
    pend_data_d = pend_data_q;
    wdata_d     = wdata_q;
    mondreg_d   = MonDReg;
    ready_d     = monitor_ready;
    error_d     = monitor_error;
    rdata_d     = av_readdata;
    wait_d      = 1'b1;
    ram_we      = 1'b0;
    ram_waddr   = addr_q;
    ram_wdata   = wdata_q;
    ram_be      = 4'hF;
    ram_raddr   = addr_q;

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          ready_d = 1'b0;
          wdata_d = pend_data_q;
          state_d = pend_wr_q ? JWR : JRD;
        end else if (jtag_op) begin
          ready_d = 1'b0;
          wdata_d = jdo[34:3];
          state_d = strobe_wr ? JWR : JRD;
        end else if (cpu_req && av_read) begin
          ram_raddr = av_address;
          state_d   = CRD;
        end else if (cpu_req && av_write) begin
          wait_d = 1'b0;
          if (debugack) begin
            ram_we    = 1'b1;
            ram_waddr = av_address;
            ram_wdata = av_writedata;
            ram_be    = av_byteenable;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      JRD: begin
        state_d = JCAP;
      end
      JCAP: begin
        mondreg_d = ram_q;
        ready_d   = 1'b1;
        if (AUTOINC) addr_d = addr_q + ADDR_W'(1);
        state_d   = IDLE;
      end
      JWR: begin
        ram_we  = 1'b1;
        ready_d = 1'b1;
        if (AUTOINC) addr_d = addr_q + ADDR_W'(1);
        state_d = IDLE;
      end
      CRD: begin
        rdata_d = ram_q;
        wait_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Park a JTAG op that arrives while the engine is busy
    if (state_q != IDLE && !pend_q && jtag_op) begin
      pend_d      = 1'b1;
      pend_wr_d   = strobe_wr;
      pend_data_d = jdo[34:3];
    end

    // Address/control load overrides everything else this cycle
    if (strobe_a) begin
      addr_d  = jdo[17 +: ADDR_W];
      ready_d = 1'b0;
      if (jdo[35]) error_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_mynios2_cpu_oci_mem_ctrl.sv
// Self-checking bench for mynios2_cpu_oci_mem_ctrl. A transaction-level
// model (word array, JTAG address, MonDReg/ready/error) is updated by the
// stimulus tasks at the edge where each effect is due; a negedge process
// compares the monitor outputs against it every cycle.
module tb_mynios2_cpu_oci_mem_ctrl;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        debugack;
  logic [7:0]  av_address;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  mynios2_cpu_oci_mem_ctrl #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .debugack                (debugack),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_byteenable           (av_byteenable),
    .av_readdata             (av_readdata),
    .av_waitrequest          (av_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  // Behavioural model
  logic [31:0] m_mem [256];
  logic [7:0]  m_addr;
  logic [31:0] m_mondreg;
  logic        m_ready;
  logic        m_error;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] a);
`ifdef MYNIOS2_OCIMEM_AUTOINC_EN
    return a + 8'd1;
`else
    return a;
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Every-cycle monitor comparison
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_mondreg", MonDReg, m_mondreg);
      check("cyc_ready", 32'(monitor_ready), 32'(m_ready));
      check("cyc_error", 32'(monitor_error), 32'(m_error));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ocimem_a: load address, optionally clear the error flag
  task automatic a_op(input logic [7:0] a, input logic clr);
    jdo = '0;
    jdo[24:17] = a;
    jdo[35] = clr;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    jdo = '0;
    m_addr = a;
    m_ready = 1'b0;
    if (clr) m_error = 1'b0;
  endtask

  task automatic jwr(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    m_ready = 1'b0;
    tick();
    m_mem[m_addr] = d;
    m_ready = 1'b1;
    m_addr = nxt(m_addr);
  endtask

  task automatic jw_at(input logic [7:0] a, input logic [31:0] d);
    a_op(a, 1'b0);
    jwr(d);
  endtask

  task automatic cpu_rd(input logic [7:0] a, input int exp_lat, output logic [31:0] d);
    int n;
    av_read = 1'b1;
    av_address = a;
    n = 0;
    do begin
      tick();
      n++;
    end while (av_waitrequest && n < 16);
    check("rd_latency", 32'(n), 32'(exp_lat));
    check("rd_data", av_readdata, m_mem[a]);
    d = av_readdata;
    tick();
    check("rd_release", 32'(av_waitrequest), 32'd1);
    av_read = 1'b0;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic dack);
    int n;
    av_write = 1'b1;
    av_address = a;
    av_writedata = d;
    av_byteenable = be;
    debugack = dack;
    n = 0;
    do begin
      tick();
      n++;
    end while (av_waitrequest && n < 16);
    check("wr_latency", 32'(n), 32'd1);
    if (dack) m_mem[a] = merge(m_mem[a], d, be);
    else m_error = 1'b1;
    tick();
    check("wr_release", 32'(av_waitrequest), 32'd1);
    av_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int n;
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    debugack = 1'b0;
    av_address = '0;
    av_read = 1'b0;
    av_write = 1'b0;
    av_writedata = '0;
    av_byteenable = '0;
    m_addr = '0;
    m_mondreg = '0;
    m_ready = 1'b0;
    m_error = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_mondreg", MonDReg, 32'h0);
    check("rst_ready", 32'(monitor_ready), 32'd0);
    check("rst_error", 32'(monitor_error), 32'd0);
    check("rst_wait", 32'(av_waitrequest), 32'd1);
    check("rst_rdata", av_readdata, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_en = 1'b1;
    tick();
    check("idle_wait", 32'(av_waitrequest), 32'd1);

    // Write DEADBEEF at 0x10 then read it back through JTAG
    jw_at(8'h10, 32'hDEADBEEF);
    a_op(8'h10, 1'b0);
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    m_ready = 1'b0;
    check("jrd_early1", MonDReg, 32'h0);
    tick();
    check("jrd_early2", MonDReg, 32'h0);
    tick();
    m_mondreg = m_mem[m_addr];
    m_ready = 1'b1;
    m_addr = nxt(m_addr);
    check("jrd_data", MonDReg, 32'hDEADBEEF);
    check("jrd_ready", 32'(monitor_ready), 32'd1);

    // Address wrap: two writes starting at 0xFF
    jw_at(8'h00, 32'h55AA55AA);
    a_op(8'hFF, 1'b0);
    jwr(32'h1);
    jwr(32'h2);
    cpu_rd(8'hFF, 2, rd);
`ifdef MYNIOS2_OCIMEM_AUTOINC_EN
    check("wrap_ff", rd, 32'h1);
`else
    check("wrap_ff", rd, 32'h2);
`endif
    cpu_rd(8'h00, 2, rd);
`ifdef MYNIOS2_OCIMEM_AUTOINC_EN
    check("wrap_00", rd, 32'h2);
`else
    check("wrap_00", rd, 32'h55AA55AA);
`endif

    // CPU read contending with a same-cycle JTAG write to the same word
    a_op(8'h10, 1'b0);
    av_read = 1'b1;
    av_address = 8'h10;
    jdo = '0;
    jdo[34:3] = 32'h12345678;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    m_ready = 1'b0;
    n = 1;
    while (av_waitrequest && n < 16) begin
      tick();
      n++;
      if (n == 2) begin
        m_mem[m_addr] = 32'h12345678;
        m_ready = 1'b1;
        m_addr = nxt(m_addr);
      end
    end
    check("cont_latency", 32'(n), 32'd4);
    check("cont_data", av_readdata, 32'h12345678);
    tick();
    av_read = 1'b0;

    // CPU write outside debug mode is rejected and flagged
    jw_at(8'h20, 32'hCAFEF00D);
    cpu_wr(8'h20, 32'h1234, 4'hF, 1'b0);
    check("err_set", 32'(monitor_error), 32'd1);
    cpu_rd(8'h20, 2, rd);
    check("err_ram", rd, 32'hCAFEF00D);
    a_op(8'h00, 1'b0);
    check("err_sticky", 32'(monitor_error), 32'd1);
    a_op(8'h00, 1'b1);
    check("err_clear", 32'(monitor_error), 32'd0);

    // Byte lanes in debug mode
    jw_at(8'h30, 32'h0);
    cpu_wr(8'h30, 32'hAABBCCDD, 4'b0010, 1'b1);
    cpu_rd(8'h30, 2, rd);
    check("be_0010", rd, 32'h0000CC00);
    cpu_wr(8'h30, 32'h11223344, 4'b1001, 1'b1);
    cpu_rd(8'h30, 2, rd);
    check("be_1001", rd, 32'h1100CC44);
    cpu_wr(8'h31, 32'h87654321, 4'hF, 1'b1);
    cpu_rd(8'h31, 2, rd);

    // Strobe priority: ocimem_a drops a same-cycle write
    jw_at(8'h50, 32'h50505050);
    jw_at(8'h52, 32'h52525252);
    jdo = '0;
    jdo[24:17] = 8'h52;
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    m_addr = 8'h52;
    m_ready = 1'b0;
    repeat (3) tick();
    cpu_rd(8'h50, 2, rd);
    cpu_rd(8'h52, 2, rd);
    check("prio_a_b", rd, 32'h52525252);

    // Strobe priority: write wins over same-cycle read
    a_op(8'h60, 1'b0);
    jdo = '0;
    jdo[34:3] = 32'h60606060;
    take_action_ocimem_b = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo = '0;
    m_ready = 1'b0;
    tick();
    m_mem[m_addr] = 32'h60606060;
    m_ready = 1'b1;
    m_addr = nxt(m_addr);
    repeat (3) tick();
    cpu_rd(8'h60, 2, rd);

    // Pending slot: read busy, write parked, third strobe dropped
    jw_at(8'h40, 32'h11111111);
    jw_at(8'h41, 32'hA1A1A1A1);
    jw_at(8'h42, 32'hA2A2A2A2);
    a_op(8'h40, 1'b0);
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    m_ready = 1'b0;
    jdo = '0;
    jdo[34:3] = 32'h22222222;
    take_action_ocimem_b = 1'b1;
    tick();
    jdo[34:3] = 32'h33333333;
    tick();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    m_mondreg = m_mem[m_addr];
    m_ready = 1'b1;
    m_addr = nxt(m_addr);
    check("pend_rd", MonDReg, 32'h11111111);
    tick();
    m_ready = 1'b0;
    tick();
    m_mem[m_addr] = 32'h22222222;
    m_ready = 1'b1;
    m_addr = nxt(m_addr);
    repeat (2) tick();
    cpu_rd(8'h40, 2, rd);
    cpu_rd(8'h41, 2, rd);
    cpu_rd(8'h42, 2, rd);

    // Reset in the middle of a JTAG write abandons it
    jw_at(8'h70, 32'h70707070);
    a_op(8'h70, 1'b0);
    jdo = '0;
    jdo[34:3] = 32'h0BAD0BAD;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    reset_n = 1'b0;
    m_addr = '0;
    m_mondreg = '0;
    m_ready = 1'b0;
    m_error = 1'b0;
    #1;
    check("mid_rst_wait", 32'(av_waitrequest), 32'd1);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    cpu_rd(8'h70, 2, rd);
    check("mid_rst_ram", rd, 32'h70707070);
    jwr(32'h0E0E0E0E);
    cpu_rd(8'h00, 2, rd);
    check("rst_addr0", rd, 32'h0E0E0E0E);

    repeat (2) tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
